// File: rtl/sig_compare_checker.sv
// Per-channel signal comparator: aligns golden data through a delay line, counts qualified
// compares and mismatches, and captures the channel and cycle of the first failure.
module sig_compare_checker #(
    parameter int unsigned WIDTH        = 9,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned LAT          = 0,
    parameter int unsigned CNT_W        = 16,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic [NUM_CH*WIDTH-1:0]   dut_val,
    input  logic [NUM_CH*WIDTH-1:0]   gold_val,
    input  logic [NUM_CH-1:0]         gold_vld,
    output logic [NUM_CH-1:0]         mismatch,
    output logic                      err_sticky,
    output logic [CNT_W-1:0]          err_count,
    output logic [CNT_W-1:0]          cmp_count,
    output logic [3:0]                first_ch,
    output logic [CNT_W-1:0]          first_cycle,
    output logic                      busy,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAIL = 2'd2
    } state_t;

    localparam int unsigned SW = CNT_W + 6;

    state_t                    r_state;
    state_t                    w_next;
    logic [NUM_CH*WIDTH-1:0]   w_gd;
    logic [NUM_CH-1:0]         w_gv;
    logic [NUM_CH-1:0]         w_raw;
    logic [3:0]                w_first;
    logic [NUM_CH-1:0]         r_mismatch;
    logic                      r_sticky;
    logic [CNT_W-1:0]          r_err;
    logic [CNT_W-1:0]          r_cmp;
    logic [CNT_W-1:0]          r_cycle;
    logic [3:0]                r_first_ch;
    logic [CNT_W-1:0]          r_first_cycle;

    function automatic logic [4:0] popcnt(input logic [NUM_CH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'({CNT_W{1'b1}})) ? '1 : s[CNT_W-1:0];
    endfunction

    // Golden alignment shifts every cycle independent of the FSM so data is aligned on RUN entry
    generate
        if (LAT == 0) begin : g_pass
            assign w_gd = gold_val;
            assign w_gv = gold_vld;
        end else begin : g_dly
            logic [NUM_CH*WIDTH-1:0] r_dv [LAT];
            logic [NUM_CH-1:0]       r_dq [LAT];

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int unsigned i = 0; i < LAT; i++) begin
                        r_dv[i] <= '0;
                        r_dq[i] <= '0;
                    end
                end else begin
                    r_dv[0] <= gold_val;
                    r_dq[0] <= gold_vld;
                    for (int unsigned i = 1; i < LAT; i++) begin
                        r_dv[i] <= r_dv[i-1];
                        r_dq[i] <= r_dq[i-1];
                    end
                end
            end

            assign w_gd = r_dv[LAT-1];
            assign w_gv = r_dq[LAT-1];
        end
    endgenerate

    always_comb begin
        w_raw = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_raw[i] = w_gv[i] && (dut_val[i*WIDTH +: WIDTH] != w_gd[i*WIDTH +: WIDTH]);
        end
    end

    // Scan downward so the lowest failing index is the one left in w_first
    always_comb begin
        w_first = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (w_raw[i-1]) begin
                w_first = 4'(i - 1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (en) w_next = RUN;
            RUN: begin
                if (STOP_ON_FAIL && (|w_raw)) begin
                    w_next = FAIL;
                end else if (!en) begin
                    w_next = IDLE;
                end
            end
            FAIL:    w_next = FAIL;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_mismatch    <= '0;
            r_sticky      <= 1'b0;
            r_err         <= '0;
            r_cmp         <= '0;
            r_cycle       <= '0;
            r_first_ch    <= '0;
            r_first_cycle <= '0;
        end else begin
            r_mismatch <= '0;
            case (r_state)
                IDLE: r_cycle <= '0;
                RUN: begin
                    r_mismatch <= w_raw;
                    r_err      <= sat_add(r_err, popcnt(w_raw));
                    r_cmp      <= sat_add(r_cmp, popcnt(w_gv));
                    r_cycle    <= sat_add(r_cycle, 5'd1);
                    if ((|w_raw) && !r_sticky) begin
                        r_sticky      <= 1'b1;
                        r_first_ch    <= w_first;
                        r_first_cycle <= r_cycle;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mismatch    = r_mismatch;
    assign err_sticky  = r_sticky;
    assign err_count   = r_err;
    assign cmp_count   = r_cmp;
    assign first_ch    = r_first_ch;
    assign first_cycle = r_first_cycle;
    assign busy        = (r_state == RUN);
    assign state       = r_state;

endmodule

// File: tb/tb_sig_compare_checker.sv
// Drives five differently-parameterised checkers with shared stimulus and compares each
// against a cycle-level behavioural model plus directed expectations.
module tb_sig_compare_checker;

    localparam int LATS  [5] = '{0, 0, 3, 2, 0};
    localparam bit STOPS [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam int CMAX  [5] = '{65535, 65535, 65535, 65535, 15};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        clr = 1'b0;
    logic [17:0] dut_val  = '0;
    logic [17:0] gold_val = '0;
    logic [1:0]  gold_vld = '0;

    // {state[57:56], busy[55], sticky[54], mm[53:52], fch[51:48], err[47:32], cmp[31:16], fcyc[15:0]}
    logic [57:0] dut_pack [5];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int CW = (g == 4) ? 4 : 16;
        logic [1:0]    mm;
        logic          sticky;
        logic [CW-1:0] ec;
        logic [CW-1:0] cc;
        logic [CW-1:0] fc;
        logic [3:0]    fch;
        logic          bsy;
        logic [1:0]    st;

        sig_compare_checker #(
            .WIDTH(9), .NUM_CH(2), .LAT(LATS[g]), .CNT_W(CW), .STOP_ON_FAIL(STOPS[g])
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .clr(clr),
            .dut_val(dut_val), .gold_val(gold_val), .gold_vld(gold_vld),
            .mismatch(mm), .err_sticky(sticky), .err_count(ec), .cmp_count(cc),
            .first_ch(fch), .first_cycle(fc), .busy(bsy), .state(st)
        );

        assign dut_pack[g] = {st, bsy, sticky, mm, fch, 16'(ec), 16'(cc), 16'(fc)};
    end

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int     mode;   // 0 idle, 1 run, 2 fail
        int     cyc;
        int     errc;
        int     cmpc;
        int     fch;
        int     fcyc;
        bit     sticky;
        bit [1:0] mm;
    } mdl_t;

    mdl_t        m  [5];
    logic [17:0] hv [8];
    logic [1:0]  hq [8];

    function automatic mdl_t step(input mdl_t c, input int cmax, input bit stop,
                                  input logic [17:0] d, input logic [17:0] gd,
                                  input logic [1:0] gv, input logic r, input logic cl,
                                  input logic e);
        mdl_t n = c;
        int ne = 0;
        int nc = 0;
        bit [1:0] raw = '0;
        if (r || cl) begin
            n = '{default: 0};
            return n;
        end
        n.mm = '0;
        if (c.mode == 0) begin
            n.cyc = 0;
            if (e) n.mode = 1;
        end else if (c.mode == 1) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (gv[ch]) nc++;
                raw[ch] = gv[ch] && (d[ch*9 +: 9] != gd[ch*9 +: 9]);
                if (raw[ch]) ne++;
            end
            n.mm   = raw;
            n.errc = (c.errc + ne > cmax) ? cmax : c.errc + ne;
            n.cmpc = (c.cmpc + nc > cmax) ? cmax : c.cmpc + nc;
            n.cyc  = (c.cyc + 1 > cmax) ? cmax : c.cyc + 1;
            if (raw != 0 && !c.sticky) begin
                n.sticky = 1'b1;
                n.fch    = raw[0] ? 0 : 1;
                n.fcyc   = c.cyc;
            end
            if (stop && raw != 0) n.mode = 2;
            else if (!e)          n.mode = 0;
        end
        return n;
    endfunction

    function automatic logic [57:0] mdl_pack(input mdl_t x);
        return {2'(x.mode), 1'(x.mode == 1), x.sticky, x.mm, 4'(x.fch),
                16'(x.errc), 16'(x.cmpc), 16'(x.fcyc)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            m[k] <= step(m[k], CMAX[k], STOPS[k], dut_val,
                         (LATS[k] == 0) ? gold_val : hv[(LATS[k] == 0) ? 0 : LATS[k] - 1],
                         (LATS[k] == 0) ? gold_vld : hq[(LATS[k] == 0) ? 0 : LATS[k] - 1],
                         rst, clr, en);
        end
        for (int i = 0; i < 8; i++) begin
            if (rst || clr) begin
                hv[i] <= '0;
                hq[i] <= '0;
            end else if (i == 0) begin
                hv[0] <= gold_val;
                hq[0] <= gold_vld;
            end else begin
                hv[i] <= hv[i-1];
                hq[i] <= hq[i-1];
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clr = 1'b1;
        dut_val = 18'($urandom); gold_val = 18'($urandom); gold_vld = 2'b11;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            for (int k = 0; k < 5; k++) begin
                n_chk++;
                if (dut_pack[k] !== 58'd0) begin
                    n_fail++;
                    $display("FAIL reset_%0d: got %h expected 0", k, dut_pack[k]);
                end
            end
        end
        rst = 1'b0; clr = 1'b0; en = 1'b0;
    endtask

    task automatic test_all_match();
        logic [17:0] v;
        clr = 1'b1; en = 1'b0;
        @(posedge clk); @(negedge clk);
        clr = 1'b0; en = 1'b1;
        for (int t = 0; t < 11; t++) begin
            v = 18'($urandom);
            dut_val = v; gold_val = v; gold_vld = 2'b11;
            @(posedge clk); @(negedge clk);
            for (int k = 0; k < 5; k++) begin
                n_chk++;
                if (dut_pack[k] !== mdl_pack(m[k])) begin
                    n_fail++;
                    $display("FAIL match_model_%0d: dut=%h model=%h", k, dut_pack[k], mdl_pack(m[k]));
                end
            end
        end
        n_chk++;
        if (dut_pack[0][47:32] !== 16'd0) begin
            n_fail++; $display("FAIL match_err: got %0d expected 0", dut_pack[0][47:32]);
        end
        n_chk++;
        if (dut_pack[0][31:16] !== 16'd20) begin
            n_fail++; $display("FAIL match_cmp: got %0d expected 20", dut_pack[0][31:16]);
        end
        n_chk++;
        if (dut_pack[0][57:54] !== 4'b0110) begin
            n_fail++; $display("FAIL match_state: got %b expected 0110", dut_pack[0][57:54]);
        end
    endtask

    task automatic test_stop_on_fail();
        logic [57:0] snap;
        clr = 1'b1; en = 1'b0;
        @(posedge clk); @(negedge clk);
        clr = 1'b0; en = 1'b1; gold_vld = 2'b11;
        dut_val = 18'($urandom); gold_val = dut_val;
        @(posedge clk); @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            dut_val = 18'($urandom); gold_val = dut_val;
            if (c == 4) begin
                dut_val[17:9] = 9'h05; gold_val[17:9] = 9'h07;
            end
            @(posedge clk); @(negedge clk);
        end
        n_chk++;
        if (dut_pack[0][53:52] !== 2'b10) begin
            n_fail++; $display("FAIL stop_mm: got %b expected 10", dut_pack[0][53:52]);
        end
        n_chk++;
        if (dut_pack[0][51:48] !== 4'd1) begin
            n_fail++; $display("FAIL stop_fch: got %0d expected 1", dut_pack[0][51:48]);
        end
        n_chk++;
        if (dut_pack[0][15:0] !== 16'd4) begin
            n_fail++; $display("FAIL stop_fcyc: got %0d expected 4", dut_pack[0][15:0]);
        end
        n_chk++;
        if (dut_pack[0][47:32] !== 16'd1) begin
            n_fail++; $display("FAIL stop_err: got %0d expected 1", dut_pack[0][47:32]);
        end
        n_chk++;
        if (dut_pack[0][57:56] !== 2'd2) begin
            n_fail++; $display("FAIL stop_state: got %0d expected 2", dut_pack[0][57:56]);
        end
        snap = {dut_pack[0][57:54], 2'b00, dut_pack[0][51:0]};
        for (int c = 0; c < 5; c++) begin
            dut_val = 18'($urandom); gold_val = 18'($urandom);
            @(posedge clk); @(negedge clk);
            n_chk++;
            if (dut_pack[0] !== snap) begin
                n_fail++; $display("FAIL stop_frozen: got %h expected %h", dut_pack[0], snap);
            end
        end
    endtask

    task automatic test_no_stop();
        clr = 1'b1; en = 1'b0;
        @(posedge clk); @(negedge clk);
        clr = 1'b0; en = 1'b1; gold_vld = 2'b11;
        dut_val = 18'($urandom); gold_val = dut_val;
        @(posedge clk); @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            gold_val = 18'($urandom); dut_val = gold_val;
            if (c == 2) dut_val = ~gold_val;
            if (c == 6) dut_val[8:0] = ~gold_val[8:0];
            @(posedge clk); @(negedge clk);
            n_chk++;
            if (dut_pack[1] !== mdl_pack(m[1])) begin
                n_fail++; $display("FAIL nostop_model: dut=%h model=%h", dut_pack[1], mdl_pack(m[1]));
            end
        end
        n_chk++;
        if (dut_pack[1][51:48] !== 4'd0) begin
            n_fail++; $display("FAIL nostop_fch: got %0d expected 0", dut_pack[1][51:48]);
        end
        n_chk++;
        if (dut_pack[1][15:0] !== 16'd2) begin
            n_fail++; $display("FAIL nostop_fcyc: got %0d expected 2", dut_pack[1][15:0]);
        end
        n_chk++;
        if (dut_pack[1][47:32] !== 16'd3) begin
            n_fail++; $display("FAIL nostop_err: got %0d expected 3", dut_pack[1][47:32]);
        end
        n_chk++;
        if (dut_pack[1][57:56] !== 2'd1) begin
            n_fail++; $display("FAIL nostop_state: got %0d expected 1", dut_pack[1][57:56]);
        end
    endtask

    task automatic test_qualifier();
        clr = 1'b1; en = 1'b0;
        @(posedge clk); @(negedge clk);
        clr = 1'b0; en = 1'b1; gold_vld = 2'b01;
        @(posedge clk); @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            gold_val = 18'($urandom); dut_val = gold_val;
            dut_val[17:9] = ~gold_val[17:9];
            @(posedge clk); @(negedge clk);
            n_chk++;
            if (dut_pack[0][53:52] !== 2'b00) begin
                n_fail++; $display("FAIL qual_mm: got %b expected 00", dut_pack[0][53:52]);
            end
            n_chk++;
            if (dut_pack[0][31:16] !== 16'(c + 1)) begin
                n_fail++; $display("FAIL qual_cmp: got %0d expected %0d", dut_pack[0][31:16], c + 1);
            end
        end
        n_chk++;
        if (dut_pack[0][47:32] !== 16'd0) begin
            n_fail++; $display("FAIL qual_err: got %0d expected 0", dut_pack[0][47:32]);
        end
    endtask

    task automatic test_latency();
        logic [17:0] g [20];
        logic [17:0] d [20];
        int exp_cyc = -1;
        int exp_ch  = 0;
        for (int t = 0; t < 20; t++) begin
            g[t] = 18'($urandom);
            d[t] = (t >= 3) ? g[t-3] : 18'($urandom);
        end
        for (int t = 2; t < 20; t++) begin
            if (exp_cyc < 0 && d[t] != g[t-2]) begin
                exp_cyc = t - 1;
                exp_ch  = (d[t][8:0] != g[t-2][8:0]) ? 0 : 1;
            end
        end
        clr = 1'b1; en = 1'b0;
        @(posedge clk); @(negedge clk);
        clr = 1'b0; en = 1'b1; gold_vld = 2'b11;
        for (int t = 0; t < 20; t++) begin
            gold_val = g[t]; dut_val = d[t];
            @(posedge clk); @(negedge clk);
            for (int k = 2; k < 4; k++) begin
                n_chk++;
                if (dut_pack[k] !== mdl_pack(m[k])) begin
                    n_fail++; $display("FAIL lat_model_%0d: dut=%h model=%h", k, dut_pack[k], mdl_pack(m[k]));
                end
            end
        end
        n_chk++;
        if (dut_pack[2][47:32] !== 16'd0) begin
            n_fail++; $display("FAIL lat3_err: got %0d expected 0", dut_pack[2][47:32]);
        end
        n_chk++;
        if (dut_pack[2][31:16] !== 16'd34) begin
            n_fail++; $display("FAIL lat3_cmp: got %0d expected 34", dut_pack[2][31:16]);
        end
        n_chk++;
        if (dut_pack[3][54] !== 1'b1 || dut_pack[3][15:0] !== 16'(exp_cyc)) begin
            n_fail++; $display("FAIL lat2_first: sticky=%b fcyc=%0d expected sticky=1 fcyc=%0d",
                               dut_pack[3][54], dut_pack[3][15:0], exp_cyc);
        end
        n_chk++;
        if (dut_pack[3][51:48] !== 4'(exp_ch)) begin
            n_fail++; $display("FAIL lat2_fch: got %0d expected %0d", dut_pack[3][51:48], exp_ch);
        end
    endtask

    task automatic test_saturation();
        clr = 1'b1; en = 1'b0;
        @(posedge clk); @(negedge clk);
        clr = 1'b0; en = 1'b1; gold_vld = 2'b01;
        @(posedge clk); @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            gold_val = 18'($urandom); dut_val = gold_val;
            dut_val[8:0] = ~gold_val[8:0];
            @(posedge clk); @(negedge clk);
            n_chk++;
            if (dut_pack[4] !== mdl_pack(m[4])) begin
                n_fail++; $display("FAIL sat_model: dut=%h model=%h", dut_pack[4], mdl_pack(m[4]));
            end
        end
        n_chk++;
        if (dut_pack[4][47:32] !== 16'd15 || dut_pack[4][31:16] !== 16'd15) begin
            n_fail++; $display("FAIL sat_counts: err=%0d cmp=%0d expected 15 15",
                               dut_pack[4][47:32], dut_pack[4][31:16]);
        end
        n_chk++;
        if (dut_pack[4][57:56] !== 2'd1) begin
            n_fail++; $display("FAIL sat_state: got %0d expected 1", dut_pack[4][57:56]);
        end
        clr = 1'b1;
        @(posedge clk); @(negedge clk);
        n_chk++;
        if (dut_pack[4] !== 58'd0) begin
            n_fail++; $display("FAIL sat_clr: got %h expected 0", dut_pack[4]);
        end
        clr = 1'b0;
        repeat (6) begin
            gold_val = 18'($urandom); dut_val = ~gold_val; gold_vld = 2'b11;
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (dut_pack[k] !== 58'd0) begin
                n_fail++; $display("FAIL midrun_rst_%0d: got %h expected 0", k, dut_pack[k]);
            end
        end
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            rst      = ($urandom_range(0, 99) == 0);
            clr      = ($urandom_range(0, 39) == 0);
            en       = ($urandom_range(0, 9) != 0);
            gold_vld = 2'($urandom);
            gold_val = 18'($urandom);
            dut_val  = gold_val;
            if ($urandom_range(0, 9) == 0) dut_val[8:0]  = 9'($urandom);
            if ($urandom_range(0, 9) == 0) dut_val[17:9] = 9'($urandom);
            @(posedge clk); @(negedge clk);
            for (int k = 0; k < 5; k++) begin
                n_chk++;
                if (dut_pack[k] !== mdl_pack(m[k])) begin
                    n_fail++; $display("FAIL random_model_%0d t=%0d: dut=%h model=%h",
                                       k, t, dut_pack[k], mdl_pack(m[k]));
                end
            end
        end
        rst = 1'b0; clr = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_match();
        test_stop_on_fail();
        test_no_stop();
        test_qualifier();
        test_latency();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
